// File: rtl/d5m_stream_gen.sv
// D5M sensor emulator: produces FVAL/LVAL-framed 12-bit raw Bayer test patterns
// with the same timing the camera presents, for bring-up without a sensor.
module d5m_stream_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_FRONT  = 4,
  parameter int unsigned V_BACK   = 4,
  parameter int unsigned V_BLANK  = 1000,
  parameter int unsigned BAR_W    = 80
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic [1:0]  iMODE,
  output logic [11:0] oDATA,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont
);

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 12;
  localparam int unsigned FW = 32;

  localparam logic [CW-1:0] X_LAST      = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST      = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] FRONT_LAST  = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] BACK_LAST   = CW'(V_BACK - 1);
  localparam logic [CW-1:0] VBLANK_LAST = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] HBLANK_LAST = CW'((H_BLANK == 0) ? 0 : H_BLANK - 1);
  localparam logic [CW-1:0] BAR_LAST    = CW'((BAR_W == 0) ? 0 : BAR_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRONT  = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    BACK   = 3'd4,
    VBLANK = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          run, run_nxt;
  logic [1:0]    mode_q, mode_nxt;
  logic [2:0]    bar, bar_nxt;
  logic [CW-1:0] bar_cnt, bar_cnt_nxt;
  logic [CW-1:0] x_nxt, y_nxt;
  logic [FW-1:0] frame_nxt;
  logic          fval_nxt, lval_nxt;
  logic [DW-1:0] pix, data_nxt;
  logic          site_bit;
  logic          start_line, next_pix;

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, counters and next output values
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    mode_nxt    = mode_q;
    bar_nxt     = bar;
    bar_cnt_nxt = bar_cnt;
    x_nxt       = oX_Cont;
    y_nxt       = oY_Cont;
    frame_nxt   = oFrame_Cont;
    start_line  = 1'b0;
    next_pix    = 1'b0;
    run_nxt     = iEND ? 1'b0 : (iSTART ? 1'b1 : run);

    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = FRONT;
          y_nxt     = '0;
          mode_nxt  = iMODE;
        end
      end
      FRONT: begin
        if (cnt == FRONT_LAST) begin
          state_nxt  = LINE;
          start_line = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LINE: begin
        if (oX_Cont == X_LAST) begin
          x_nxt = '0;
          if (oY_Cont < Y_LAST) begin
            // Zero horizontal blanking chains lines back-to-back
            if (H_BLANK == 0) begin
              start_line = 1'b1;
              y_nxt      = oY_Cont + CW'(1);
            end else begin
              state_nxt = HBLANK;
            end
          end else begin
            state_nxt = BACK;
          end
        end else begin
          next_pix = 1'b1;
        end
      end
      HBLANK: begin
        if (cnt == HBLANK_LAST) begin
          state_nxt  = LINE;
          start_line = 1'b1;
          y_nxt      = oY_Cont + CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      BACK: begin
        if (cnt == BACK_LAST) begin
          state_nxt = VBLANK;
          frame_nxt = oFrame_Cont + FW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      VBLANK: begin
        if (cnt == VBLANK_LAST) begin
          if (run) begin
            state_nxt = FRONT;
            y_nxt     = '0;
            mode_nxt  = iMODE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;

    if (start_line) begin
      x_nxt       = '0;
      bar_nxt     = '0;
      bar_cnt_nxt = '0;
    end else if (next_pix) begin
      x_nxt = oX_Cont + CW'(1);
      if (bar_cnt == BAR_LAST) begin
        bar_cnt_nxt = '0;
        bar_nxt     = bar + 3'(1);
      end else begin
        bar_cnt_nxt = bar_cnt + CW'(1);
      end
    end

    fval_nxt = (state_nxt == FRONT) || (state_nxt == LINE) ||
               (state_nxt == HBLANK) || (state_nxt == BACK);
    lval_nxt = (state_nxt == LINE);

    // Bayer site colour: even/even G, even/odd R, odd/even B, odd/odd G
    case ({y_nxt[0], x_nxt[0]})
      2'b01:   site_bit = bar_nxt[2];
      2'b10:   site_bit = bar_nxt[0];
      default: site_bit = bar_nxt[1];
    endcase

    case (mode_nxt)
      2'd0:    pix = x_nxt[DW-1:0];
      2'd1:    pix = y_nxt[DW-1:0];
      2'd2:    pix = {DW{site_bit}};
      default: pix = {DW{x_nxt[3] ^ y_nxt[3] ^ oFrame_Cont[0]}};
    endcase

    data_nxt = lval_nxt ? pix : '0;
  end

  // Registered datapath and outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt         <= '0;
      run         <= 1'b0;
      mode_q      <= '0;
      bar         <= '0;
      bar_cnt     <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oFrame_Cont <= '0;
      oFVAL       <= 1'b0;
      oLVAL       <= 1'b0;
      oDATA       <= '0;
    end else begin
      cnt         <= cnt_nxt;
      run         <= run_nxt;
      mode_q      <= mode_nxt;
      bar         <= bar_nxt;
      bar_cnt     <= bar_cnt_nxt;
      oX_Cont     <= x_nxt;
      oY_Cont     <= y_nxt;
      oFrame_Cont <= frame_nxt;
      oFVAL       <= fval_nxt;
      oLVAL       <= lval_nxt;
      oDATA       <= data_nxt;
    end
  end

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Directed bench for d5m_stream_gen on a tiny 8x4 frame: timing, patterns,
// run control, mid-frame mode change and asynchronous reset.
module tb_d5m_stream_gen;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 3;
  localparam int VF = 2;
  localparam int VB = 2;
  localparam int VBL = 5;
  localparam int BW = 1;
  localparam int FV_CYC = VF + VA * HA + (VA - 1) * HB + VB;  // 45
  localparam int PERIOD = FV_CYC + VBL;                        // 50

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iSTART;
  logic        iEND;
  logic [1:0]  iMODE;
  logic [11:0] oDATA;
  logic        oFVAL;
  logic        oLVAL;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic [31:0] oFrame_Cont;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  // Mode 2 rows with BAR_W=1 (bar index equals x)
  logic [11:0] row_even [8] = '{12'h000, 12'h000, 12'hFFF, 12'h000,
                                12'h000, 12'hFFF, 12'hFFF, 12'hFFF};
  logic [11:0] row_odd  [8] = '{12'h000, 12'h000, 12'h000, 12'hFFF,
                                12'h000, 12'h000, 12'h000, 12'hFFF};

  always #5 iCLK = ~iCLK;

  d5m_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_FRONT(VF),
    .V_BACK(VB), .V_BLANK(VBL), .BAR_W(BW)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iEND(iEND), .iMODE(iMODE),
    .oDATA(oDATA), .oFVAL(oFVAL), .oLVAL(oLVAL), .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge iCLK);
  endtask

  function automatic logic [11:0] exp_pix(input int mode, input int x, input int y, input int fr);
    case (mode)
      0:       return 12'(x);
      1:       return 12'(y);
      2:       return (y % 2 == 0) ? row_even[x] : row_odd[x];
      default: return ((((x / 8) ^ (y / 8) ^ fr) & 1) != 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Step until FVAL rises; lat = negedges stepped
  task automatic wait_rise(output int n);
    n = 0;
    for (int i = 0; i < 20 && oFVAL !== 1'b1; i++) begin
      step();
      n++;
    end
    chk("fval_rise", 32'(oFVAL), 32'd1);
  endtask

  // Check one full frame period starting at the first FVAL-high sample
  task automatic run_frame(input int mode, input int base, input logic [1:0] next_mode,
                           input bit do_end);
    int ln, ph, e_x, e_y, e_fr;
    bit in_act, e_fval, e_lval;
    logic [11:0] e_d;
    for (int k = 0; k < PERIOD; k++) begin
      e_fval = (k < FV_CYC);
      in_act = (k >= VF) && (k < FV_CYC - VB);
      ln = 0;
      ph = 0;
      if (in_act) begin
        ln = (k - VF) / (HA + HB);
        ph = (k - VF) % (HA + HB);
      end
      e_lval = in_act && (ph < HA);
      e_x    = e_lval ? ph : 0;
      e_y    = (k < VF) ? 0 : (in_act ? ln : VA - 1);
      e_fr   = (k >= FV_CYC) ? base + 1 : base;
      e_d    = e_lval ? exp_pix(mode, e_x, e_y, base) : 12'h000;
      chk($sformatf("f%0d k%0d fval", base, k), 32'(oFVAL), 32'(e_fval));
      chk($sformatf("f%0d k%0d lval", base, k), 32'(oLVAL), 32'(e_lval));
      chk($sformatf("f%0d k%0d x", base, k), 32'(oX_Cont), 32'(e_x));
      chk($sformatf("f%0d k%0d y", base, k), 32'(oY_Cont), 32'(e_y));
      chk($sformatf("f%0d k%0d frame", base, k), oFrame_Cont, 32'(e_fr));
      chk($sformatf("f%0d k%0d data", base, k), 32'(oDATA), 32'(e_d));
      if (k == 20) iMODE = next_mode;
      if (k == 26 && do_end) iEND = 1'b1;
      if (k == 27) iEND = 1'b0;
      step();
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iMODE  = 2'd0;
    repeat (3) step();
    chk("rst_fval", 32'(oFVAL), 32'd0);
    chk("rst_lval", 32'(oLVAL), 32'd0);
    chk("rst_data", 32'(oDATA), 32'd0);
    chk("rst_x", 32'(oX_Cont), 32'd0);
    chk("rst_y", 32'(oY_Cont), 32'd0);
    chk("rst_frame", oFrame_Cont, 32'd0);

    iRST_N = 1'b1;
    repeat (3) step();
    chk("idle_no_start", 32'(oFVAL), 32'd0);

    // One edge sets run, the next leaves IDLE
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    wait_rise(lat);
    chk("start_latency", 32'(lat), 32'd1);

    run_frame(0, 0, 2'd0, 1'b0);
    run_frame(0, 1, 2'd1, 1'b0);  // mode change held off until next FRONT
    run_frame(1, 2, 2'd2, 1'b0);
    run_frame(2, 3, 2'd3, 1'b0);
    run_frame(3, 4, 2'd3, 1'b0);
    run_frame(3, 5, 2'd3, 1'b1);  // iEND in line 2: frame still completes

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ended_idle %0d", i), 32'(oFVAL), 32'd0);
      step();
    end
    chk("ended_frame", oFrame_Cont, 32'd6);

    iSTART = 1'b1;
    iEND   = 1'b1;
    step();
    iSTART = 1'b0;
    iEND   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("start_end_tie %0d", i), 32'(oFVAL), 32'd0);
      step();
    end

    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
    wait_rise(lat);
    chk("restart_latency", 32'(lat), 32'd1);
    chk("restart_frame", oFrame_Cont, 32'd6);
    repeat (5) step();
    chk("pre_rst_lval", 32'(oLVAL), 32'd1);
    chk("pre_rst_x", 32'(oX_Cont), 32'd3);

    // Reset between edges must clear outputs without a clock
    #2 iRST_N = 1'b0;
    #1;
    chk("arst_fval", 32'(oFVAL), 32'd0);
    chk("arst_lval", 32'(oLVAL), 32'd0);
    chk("arst_data", 32'(oDATA), 32'd0);
    chk("arst_x", 32'(oX_Cont), 32'd0);
    chk("arst_y", 32'(oY_Cont), 32'd0);
    chk("arst_frame", oFrame_Cont, 32'd0);
    step();
    iRST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("post_rst_idle %0d", i), 32'(oFVAL), 32'd0);
      step();
    end
    chk("post_rst_frame", oFrame_Cont, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d5m_stream_gen.md
Name: d5m_stream_gen

Overview:
Synthesizable D5M sensor emulator. Drives the same pixel-stream protocol the camera presents on GPIO1: 12-bit raw Bayer data with frame-valid and line-valid. Feeds the capture/RAW2RGB/SDRAM chain with deterministic frames for bring-up and regression without a sensor attached. Selected by a top-level mux in place of the registered D5M_D/FVAL/LVAL.

Parameters:
H_ACTIVE, 640, active pixels per line (LVAL high cycles)
V_ACTIVE, 480, active lines per frame
H_BLANK, 160, LVAL-low cycles between lines inside a frame
V_FRONT, 4, cycles with FVAL high, LVAL low before first line
V_BACK, 4, cycles with FVAL high, LVAL low after last line
V_BLANK, 1000, FVAL-low cycles between frames
BAR_W, 80, pixels per colour bar (mode 2)

Ports:
iCLK  in  1  pixel clock; all outputs change on rising edge
iRST_N  in  1  asynchronous active-low reset
iSTART  in  1  level/pulse; sets run flag
iEND  in  1  level/pulse; clears run flag
iMODE  in  2  pattern select: 0 H-ramp, 1 V-ramp, 2 Bayer colour bars, 3 checker
oDATA  out  12  raw pixel; 0 whenever oLVAL=0
oFVAL  out  1  frame valid
oLVAL  out  1  line valid
oX_Cont  out  16  pixel index in current line (0..H_ACTIVE-1), 0 outside LINE
oY_Cont  out  16  line index in current frame (0..V_ACTIVE-1)
oFrame_Cont  out  32  completed frames, wraps at 2^32

Behaviour:
- One clock (iCLK). Reset is asynchronous, active-low. On iRST_N=0, immediately: all outputs 0, run=0, state IDLE, all counters 0. Reset mid-frame aborts the frame; no partial-frame completion is counted.
- All outputs are registered and reflect the state entered on the same edge.
- Run flag: iEND=1 clears it, else iSTART=1 sets it. iEND wins on the same cycle. Run is consulted only in IDLE and at the end of VBLANK, so frames are never truncated.
- FSM states: IDLE, FRONT, LINE, HBLANK, BACK, VBLANK.
  - IDLE: FVAL=0, LVAL=0. If run=1, go to FRONT next edge.
  - FRONT: FVAL=1, LVAL=0 for exactly V_FRONT cycles, then LINE.
  - LINE: FVAL=1, LVAL=1 for exactly H_ACTIVE cycles; oX_Cont increments 0..H_ACTIVE-1. After the last pixel: HBLANK if oY_Cont<V_ACTIVE-1, else BACK.
  - HBLANK: FVAL=1, LVAL=0 for H_BLANK cycles; oY_Cont increments on exit; then LINE.
  - BACK: FVAL=1, LVAL=0 for V_BACK cycles, then VBLANK. oFrame_Cont increments on the edge entering VBLANK (FVAL fall).
  - VBLANK: FVAL=0 for V_BLANK cycles; then FRONT if run=1, else IDLE. oY_Cont is cleared entering FRONT.
- FVAL-high cycles per frame: V_FRONT + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BACK.
- iMODE is sampled on the edge entering FRONT and held for the whole frame.
- Pixel data (x=oX_Cont, y=oY_Cont, registered with LVAL):
  - mode 0: x[11:0].
  - mode 1: y[11:0].
  - mode 2: bar index b (3 bits) resets to 0 at each line start and increments mod 8 every BAR_W pixels. Bayer site: even row/even col = G, even/odd = R, odd/even = B, odd/odd = G. Output is 12'hFFF if the site colour bit is set (R=b[2], G=b[1], B=b[0]), else 0.
  - mode 3: 12'hFFF if x[3]^y[3]^oFrame_Cont[0], else 0.
- Counter widths are 16 bits; parameters must not exceed 65535. H_ACTIVE, V_ACTIVE, V_FRONT, V_BACK and V_BLANK must each be at least 1. H_BLANK=0 is legal: LINE follows LINE back-to-back with LVAL held high and oY_Cont stepping at the boundary.

Test Plan:
(Bench params: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, V_FRONT=2, V_BACK=2, V_BLANK=5, BAR_W=1.)
- Reset, then iSTART one cycle, run held, mode 0 -> FVAL high 45 cycles, LVAL high 4 bursts of 8, each burst oDATA 0..7. Frame period 50 cycles; oFrame_Cont=1 on the first FVAL fall, 2 after the next.
- Mode 2, first frame -> row0 data 000,000,FFF,000,000,FFF,FFF,FFF; row1 data 000,000,000,FFF,000,000,000,FFF.
- iEND asserted mid-frame (line 2) -> current frame completes all 4 lines, oFrame_Cont increments, then IDLE with FVAL=0. iSTART and iEND on the same cycle in IDLE -> stays IDLE.
- iMODE changed 0->1 mid-frame -> data stays x-ramp until the next FRONT; the next frame shows line n = n on every pixel.
- iRST_N low during LINE, asynchronous to the edge -> all outputs 0 without waiting for a clock edge; oFrame_Cont 0; no frame emitted until a new iSTART.
- Mode 3 over two frames -> pixel (0,0) 000 in frame 0 and FFF in frame 1; oDATA=0 in every LVAL-low cycle.
